// File: rtl/design_switch_ctrl.sv
// ----------------------------------------------------------------------------
// design_switch_ctrl
//
// Sequences a safe run-time change of the multiplexer's design_sel between
// hosted designs. A switch holds the running design in reset, parks the pad
// mux on an all-outputs-disabled selection, applies the new selection, and
// then releases reset. At power-up the initial selection is taken from strap
// pins through a 2-flop synchroniser.
//
// Ports:
//   clk_i          system clock
//   rst_n          asynchronous active-low reset
//   strap_sel_i    boot selection from pads (asynchronous, synchronised here)
//   req_valid_i    switch request valid
//   req_sel_i      requested design selection
//   req_ready_o    request accepted on any edge where valid && ready
//   design_sel_o   drives the multiplexer's design_sel
//   design_rst_n_o 0 = all designs held in reset (gates rst_override_n_*)
//   cur_sel_o      last committed selection
//   busy_o         a sequence is in progress
//   done_o         one-cycle pulse when a sequence completes
// ----------------------------------------------------------------------------
module design_switch_ctrl #(
    parameter logic [4:0]  PARK_SEL      = 5'b00000,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [4:0] strap_sel_i,
    input  logic       req_valid_i,
    input  logic [4:0] req_sel_i,
    output logic       req_ready_o,
    output logic [4:0] design_sel_o,
    output logic       design_rst_n_o,
    output logic [4:0] cur_sel_o,
    output logic       busy_o,
    output logic       done_o
);

    // A dwell of 0 behaves as 1; the counter is loaded with (dwell - 1).
    localparam int unsigned HOLD_DW   = (HOLD_CYCLES == 0)   ? 1 : HOLD_CYCLES;
    localparam int unsigned SETTLE_DW = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_DW - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_DW - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_QUIESCE,
        ST_PARK,
        ST_APPLY,
        ST_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       boot_cnt_q, boot_cnt_d;
    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       target_q, target_d;
    logic [4:0]       cur_q, cur_d;

    logic [4:0]       sel_q, sel_d;
    logic             drst_n_q, drst_n_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;

    // ready_q is only ever high in RUN, so this is the handshake itself.
    assign accept = req_valid_i && ready_q;

    // ------------------------------------------------------------------------
    // Next-state, dwell counter and selection bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        boot_cnt_d = boot_cnt_q;
        target_d   = target_q;
        cur_d      = cur_q;

        case (state_q)
            ST_BOOT: begin
                // Two cycles to fill the strap synchroniser before sampling it.
                if (boot_cnt_q == 2'd2) begin
                    target_d = sync2_q;
                    cnt_d    = SETTLE_LD;
                    state_d  = ST_PARK;
                end else begin
                    boot_cnt_d = boot_cnt_q + 2'd1;
                end
            end

            ST_RUN: begin
                // A request for the already-committed selection is consumed
                // without running a sequence.
                if (accept && (req_sel_i != cur_q)) begin
                    target_d = req_sel_i;
                    cnt_d    = HOLD_LD;
                    state_d  = ST_QUIESCE;
                end
            end

            ST_QUIESCE: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_PARK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PARK: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_APPLY: begin
                if (cnt_q == '0) begin
                    // Commit on entry to RELEASE so cur_sel_o already shows
                    // the new selection in the cycle done_o pulses.
                    cur_d   = target_q;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so every output is a register that
    // reflects the state the machine is in during that cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        sel_d    = PARK_SEL;
        drst_n_d = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;

        case (state_d)
            ST_RUN: begin
                sel_d    = cur_d;
                drst_n_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
            ST_QUIESCE: begin
                sel_d = cur_d;
            end
            ST_PARK: begin
                sel_d = PARK_SEL;
            end
            ST_APPLY: begin
                sel_d = target_d;
            end
            ST_RELEASE: begin
                sel_d  = target_d;
                done_d = 1'b1;
            end
            default: begin
                sel_d = PARK_SEL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, synchroniser and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            cnt_q      <= '0;
            boot_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            target_q   <= PARK_SEL;
            cur_q      <= PARK_SEL;
            sel_q      <= PARK_SEL;
            drst_n_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            boot_cnt_q <= boot_cnt_d;
            sync1_q    <= strap_sel_i;
            sync2_q    <= sync1_q;
            target_q   <= target_d;
            cur_q      <= cur_d;
            sel_q      <= sel_d;
            drst_n_q   <= drst_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign design_sel_o   = sel_q;
    assign design_rst_n_o = drst_n_q;
    assign cur_sel_o      = cur_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: doc/design_switch_ctrl.md
Name: design_switch_ctrl

Overview:
- Sequences safe run-time switching of the multiplexer's `design_sel` between the hosted designs (6502, C64 PLA, SID, GPIO chip, DRAM controller, NTSC).
- On a switch it does four things in order:
  - holds the running design in reset;
  - parks the pad mux on an all-outputs-disabled selection;
  - applies the new selection;
  - releases reset.
- At power-up it loads the initial selection from strap pins.
- Sits between the top-level config/strap logic and the multiplexer's `design_sel` input. `design_rst_n_o` gates all `rst_override_n_*` outputs.

Parameters:
- PARK_SEL, 5'b00000, selection that drives every pad with oe=0, cs/pu/pd=0 (the mux default case)
- HOLD_CYCLES, 16, cycles the old design is held in reset before the pads are parked; 0 behaves as 1
- SETTLE_CYCLES, 4, dwell cycles in each of PARK and APPLY; 0 behaves as 1
- CNT_W, 8, width of the internal dwell counter; it must hold max(HOLD_CYCLES, SETTLE_CYCLES)

Ports:
- clk_i  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- strap_sel_i  input  5  boot selection from pads; asynchronous, synchronised internally
- req_valid_i  input  1  switch request valid
- req_sel_i  input  5  requested design selection
- req_ready_o  output  1  request accepted on any edge where valid && ready
- design_sel_o  output  5  drives the multiplexer's design_sel
- design_rst_n_o  output  1  0 = all designs held in reset; ANDed with the mux rst_override_n_* outputs
- cur_sel_o  output  5  last committed selection
- busy_o  output  1  a sequence is in progress
- done_o  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset is asynchronous, active-low, and may occur at any point in a sequence. It returns every output at once to these values:
  - design_sel_o=PARK_SEL, design_rst_n_o=0, cur_sel_o=PARK_SEL
  - req_ready_o=0, busy_o=1, done_o=0
  - state=BOOT, counter=0, strap synchroniser cleared
- All outputs are registered and are a function of the current state only.
- Strap synchroniser: 2-flop, per bit.
- States:
  - BOOT:
    - stays for 2 cycles after reset release to fill the synchroniser;
    - then latches the synchronised strap into target and goes to PARK.
  - RUN:
    - design_rst_n_o=1, req_ready_o=1, busy_o=0, design_sel_o=cur_sel_o.
    - On accept with req_sel_i==cur_sel_o: no-op. Stay in RUN, no done_o pulse.
    - On accept with a different value: latch target and go to QUIESCE.
  - QUIESCE: design_rst_n_o=0, design_sel_o=cur_sel_o, lasts HOLD_CYCLES cycles, then PARK.
  - PARK: design_rst_n_o=0, design_sel_o=PARK_SEL, lasts SETTLE_CYCLES cycles, then APPLY.
  - APPLY: design_rst_n_o=0, design_sel_o=target, lasts SETTLE_CYCLES cycles, then RELEASE.
  - RELEASE:
    - lasts 1 cycle: design_rst_n_o=0, design_sel_o=target, done_o=1, cur_sel_o<=target;
    - then RUN.
- busy_o=1 in every state except RUN. req_ready_o=1 only in RUN.
- Requests made while busy are not accepted. The requester must hold req_valid_i/req_sel_i until it sees ready; the block does not queue them.
- Timing for an accept at edge k, with H=HOLD_CYCLES and S=SETTLE_CYCLES:

  | Output | Cycles |
  |---|---|
  | design_rst_n_o low | k+1 .. k+H+2S+1 |
  | design_sel_o = PARK_SEL | cycles k+H+1 .. k+H+S |
  | design_sel_o = target | from k+H+S+1 |
  | done_o | k+H+2S+1 |
  | design_rst_n_o high (RUN) | from k+H+2S+2 |

  Total busy time is H+2S+1 cycles.
- Selection never changes while design_rst_n_o=1. design_sel_o never moves directly from old to new; it always passes through PARK_SEL.
- A target equal to PARK_SEL is legal. The full sequence runs and ends in RUN with design_sel_o=PARK_SEL.
- Strap changes after BOOT are ignored.
- Dwell counter: loads (dwell-1) on state entry, decrements, and exits at 0. No wrap.

Test Plan:
- Boot: strap=5'b11010, release rst_n.
  - design_sel_o=00000 for 6 cycles, then 11010;
  - done_o pulses at cycle 11;
  - design_rst_n_o=1 from cycle 12;
  - cur_sel_o=11010.
- Switch from RUN at 11010, request 11011, accept at edge k with defaults:
  - rst low from k+1;
  - sel 00000 over k+17..k+20;
  - sel 11011 from k+21;
  - done_o at k+25;
  - rst high at k+26.
- Same-selection request 11011 while in RUN:
  - accepted in 1 cycle;
  - busy_o, design_rst_n_o and design_sel_o unchanged;
  - no done_o.
- Request 11110 asserted at k+5 during a switch:
  - ready stays 0 until RUN, then the request is accepted;
  - a second full sequence ends with cur_sel_o=11110.
- rst_n asserted during APPLY:
  - outputs immediately go to design_sel_o=00000, design_rst_n_o=0, busy_o=1;
  - after release, the boot sequence re-applies the current strap.
- Parameters HOLD_CYCLES=0, SETTLE_CYCLES=0:
  - QUIESCE, PARK and APPLY each last 1 cycle;
  - total busy is 4 cycles.
